// File: rtl/scan_mux_if.sv
// scan_mux bus: packed channel inputs, select/mode controls and registered outputs.
// ChMask exists only when SCAN_MUX_MASK_EN is defined.
interface scan_mux_if #(
    parameter int W = 8,
    parameter int N = 4
);
    localparam int SELW = $clog2(N);

    logic [N*W-1:0]  Din;
    logic [SELW-1:0] Sel;
    logic            Auto;
`ifdef SCAN_MUX_MASK_EN
    logic [N-1:0]    ChMask;
`endif
    logic [W-1:0]    Dout;
    logic [SELW-1:0] ChIdx;
    logic            ChChange;

    modport master (
`ifdef SCAN_MUX_MASK_EN
        output ChMask,
`endif
        output Din, Sel, Auto,
        input  Dout, ChIdx, ChChange
    );

    modport slave (
`ifdef SCAN_MUX_MASK_EN
        input  ChMask,
`endif
        input  Din, Sel, Auto,
        output Dout, ChIdx, ChChange
    );
endinterface

// File: rtl/scan_mux.sv
// scan_mux: N-channel registered selector, manual select or auto-scan every DWELL clocks.
// Optional channel mask enabled by defining SCAN_MUX_MASK_EN.
module scan_mux #(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int DWELL = 3
) (
    input  logic        Clock,
    input  logic        Resetn,
    scan_mux_if.slave   bus
);
    localparam int SELW = $clog2(N);
    localparam int SW1  = SELW + 1;
    localparam int CW   = $clog2(DWELL) + 1;

    typedef enum logic {MANUAL, AUTO} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [SELW-1:0]   r_chidx;
    logic [SELW-1:0]   w_nidx;
    logic [SELW-1:0]   w_scan_nxt;
    logic [W-1:0]      r_dout;
    logic              r_chg;
    logic [N-1:0]      w_elig;
    logic [(1<<SELW)-1:0] w_elig_ext;
    logic [SW1-1:0]    w_j;
    logic              w_found;

    // Channel eligibility, padded to the full select range so Sel can index it directly.
    always_comb begin
`ifdef SCAN_MUX_MASK_EN
        w_elig = bus.ChMask;
`else
        w_elig = '1;
`endif
        w_elig_ext = '0;
        w_elig_ext[N-1:0] = w_elig;
    end

    // Next eligible channel after the current one, wrapping; holds when none is found.
    always_comb begin
        w_scan_nxt = r_chidx;
        w_found    = 1'b0;
        w_j        = '0;
        for (int k = 1; k < N; k++) begin
            w_j = {1'b0, r_chidx} + SW1'(k);
            if (w_j >= SW1'(N)) begin
                w_j = w_j - SW1'(N);
            end
            if (!w_found && w_elig_ext[w_j[SELW-1:0]]) begin
                w_scan_nxt = w_j[SELW-1:0];
                w_found    = 1'b1;
            end
        end
    end

    // Mode follows Auto one clock late; dwell counter and next index per mode.
    always_comb begin
        w_state_nxt = bus.Auto ? AUTO : MANUAL;
        w_cnt_nxt   = '0;
        w_nidx      = r_chidx;
        unique case (r_state)
            MANUAL: begin
                if (w_elig_ext[bus.Sel]) begin
                    w_nidx = bus.Sel;
                end
            end
            AUTO: begin
                if (r_cnt == CW'(DWELL - 1)) begin
                    w_nidx = w_scan_nxt;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        endcase
    end

    // State, counter and registered outputs; Dout refreshed from Din every clock.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= MANUAL;
            r_cnt   <= '0;
            r_chidx <= '0;
            r_dout  <= '0;
            r_chg   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_chidx <= w_nidx;
            r_dout  <= bus.Din[w_nidx*W +: W];
            r_chg   <= (w_nidx != r_chidx);
        end
    end

    assign bus.Dout     = r_dout;
    assign bus.ChIdx    = r_chidx;
    assign bus.ChChange = r_chg;
endmodule

// File: tb/tb_scan_mux.sv
// Scoreboard bench for scan_mux: reference model pushes expectations, monitor pops and compares.
// Mask scenarios run when SCAN_MUX_MASK_EN is defined.
module tb_scan_mux;
    localparam int W     = 8;
    localparam int N     = 4;
    localparam int DWELL = 3;
    localparam int SELW  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    scan_mux_if #(.W(W), .N(N)) bus ();

    scan_mux #(.W(W), .N(N), .DWELL(DWELL)) dut (
        .Clock  (clk),
        .Resetn (rst_n),
        .bus    (bus.slave)
    );

    logic [W-1:0]    din [N];
    logic [SELW-1:0] sel;
    logic            auto;
    logic [N-1:0]    mask;

    always_comb begin
        bus.Din = '0;
        for (int k = 0; k < N; k++) begin
            bus.Din[k*W +: W] = din[k];
        end
    end
    assign bus.Sel  = sel;
    assign bus.Auto = auto;
`ifdef SCAN_MUX_MASK_EN
    assign bus.ChMask = mask;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endfunction

    typedef struct {
        logic [W-1:0] dout;
        int           idx;
        logic         chg;
    } exp_t;

    exp_t q[$];

    function automatic bit elig(int k);
        if (k < 0 || k >= N) return 1'b0;
`ifdef SCAN_MUX_MASK_EN
        return mask[k];
`else
        return 1'b1;
`endif
    endfunction

    function automatic int next_elig(int cur);
        for (int k = 1; k < N; k++) begin
            if (elig((cur + k) % N)) return (cur + k) % N;
        end
        return cur;
    endfunction

    // Reference model: mode seen one clock late, advance after DWELL clocks in auto mode.
    int m_idx   = 0;
    int m_ticks = 0;
    bit m_auto  = 1'b0;

    initial forever begin
        int   nidx;
        exp_t e;
        @(posedge clk);
        if (!rst_n) begin
            m_idx   = 0;
            m_ticks = 0;
            m_auto  = 1'b0;
        end else begin
            nidx = m_idx;
            if (m_auto) begin
                m_ticks++;
                if (m_ticks == DWELL) begin
                    m_ticks = 0;
                    nidx    = next_elig(m_idx);
                end
            end else begin
                m_ticks = 0;
                if (elig(int'(sel))) nidx = int'(sel);
            end
            e.chg  = (nidx != m_idx);
            e.idx  = nidx;
            e.dout = din[nidx];
            q.push_back(e);
            m_idx  = nidx;
            m_auto = auto;
        end
    end

    // Monitor: outputs are presented every clock; compare just after the edge.
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            check("rst_dout", 32'(bus.Dout), 32'h0);
            check("rst_chidx", 32'(bus.ChIdx), 32'h0);
            check("rst_chchange", 32'(bus.ChChange), 32'h0);
            q.delete();
        end else if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_empty actual=0 entries required=1 entry t=%0t", $time);
        end else begin
            e = q.pop_front();
            check("dout", 32'(bus.Dout), 32'(e.dout));
            check("chidx", 32'(bus.ChIdx), 32'(e.idx));
            check("chchange", 32'(bus.ChChange), 32'(e.chg));
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_dout", 32'(bus.Dout), 32'h0);
        check("async_chidx", 32'(bus.ChIdx), 32'h0);
        check("async_chchange", 32'(bus.ChChange), 32'h0);
        cyc(2);
        auto  = 1'b0;
        sel   = '0;
        rst_n = 1'b1;
    endtask

    initial begin
        din  = '{8'h11, 8'h22, 8'h33, 8'h44};
        sel  = '0;
        auto = 1'b0;
        mask = '1;
        #1 rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        sel = 2'd2;
        cyc(3);
        auto = 1'b1;
        cyc(16);
        sel = 2'd1;
        cyc(1);
        auto = 1'b0;
        cyc(3);
        auto = 1'b1;
        cyc(8);
        auto = 1'b0;
        sel  = 2'd2;
        cyc(3);
        din[2] = 8'hA5;
        cyc(3);
`ifdef SCAN_MUX_MASK_EN
        mask = 4'b1010;
        auto = 1'b1;
        cyc(14);
        mask = 4'b0000;
        cyc(8);
        auto = 1'b0;
        mask = 4'b1010;
        sel  = 2'd0;
        cyc(3);
        mask = '1;
        cyc(1);
`endif
        auto = 1'b1;
        cyc(5);
        async_reset();
        cyc(3);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) sel = SELW'($urandom_range(0, N - 1));
            if ($urandom_range(0, 15) == 0) auto = ~auto;
            if ($urandom_range(0, 7) == 0) din[$urandom_range(0, N - 1)] = W'($urandom);
`ifdef SCAN_MUX_MASK_EN
            if ($urandom_range(0, 19) == 0) mask = N'($urandom);
`endif
            if (i == 300) async_reset();
            cyc(1);
        end
        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
